// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - PC, instruction bus and decode handshake bundle for inst_fetch_queue
//
// Groups every non-clock/reset signal of the fetch queue.
//   PC side     : pc_ce, pc (to queue), pc_en (from queue)
//   Bus request : inst_req, inst_addr (from queue), inst_addr_ok (to queue)
//   Bus response: inst_data_ok, inst_rdata (to queue)
//   Pipeline    : flush (to queue)
//   Decode side : id_valid, id_pc, id_inst (from queue), id_ready (to queue)
// The queue uses the slave modport; the environment driving it uses master.
interface inst_fetch_queue_if #(
  parameter int WIDTH = 32
);
  logic             pc_ce;
  logic [WIDTH-1:0] pc;
  logic             pc_en;
  logic             inst_req;
  logic [WIDTH-1:0] inst_addr;
  logic             inst_addr_ok;
  logic             inst_data_ok;
  logic [WIDTH-1:0] inst_rdata;
  logic             flush;
  logic             id_valid;
  logic             id_ready;
  logic [WIDTH-1:0] id_pc;
  logic [WIDTH-1:0] id_inst;

  modport slave (
    input  pc_ce, pc, inst_addr_ok, inst_data_ok, inst_rdata, flush, id_ready,
    output pc_en, inst_req, inst_addr, id_valid, id_pc, id_inst
  );

  modport master (
    output pc_ce, pc, inst_addr_ok, inst_data_ok, inst_rdata, flush, id_ready,
    input  pc_en, inst_req, inst_addr, id_valid, id_pc, id_inst
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - in-order instruction fetch queue between PC register and decode
//
// Issues fetch requests for the current PC, remembers each accepted PC in a
// circular buffer, fills entries in request order as responses return and
// presents the oldest filled entry to decode. A flush empties the buffer and
// arms a discard counter so responses still in flight are silently dropped.
//
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : inst_fetch_queue_if.slave (PC, instruction bus, flush, decode)
module inst_fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  inst_fetch_queue_if.slave    bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Entry storage
  logic [WIDTH-1:0] pc_q     [DEPTH];
  logic [WIDTH-1:0] inst_q   [DEPTH];
  logic [DEPTH-1:0] filled_q;

  // Pointers and counters
  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0] fill_ptr_q,  fill_ptr_d;
  logic [PW-1:0] head_ptr_q,  head_ptr_d;
  logic [CW-1:0] count_q,     count_d;
  // Allocated-but-unfilled entries; kept explicitly because alloc_ptr and
  // fill_ptr alone cannot tell "none pending" from "DEPTH pending".
  logic [CW-1:0] pend_q,      pend_d;
  logic [CW-1:0] discard_q,   discard_d;

  logic req;
  logic accept;
  logic drop;
  logic fill;
  logic head_valid;
  logic pop;

  assign req        = bus.pc_ce & ~bus.flush & (count_q < FULL);
  assign accept     = req & bus.inst_addr_ok;
  // Responses are consumed by the discard counter first: everything issued
  // before the last flush returns ahead of anything issued after it.
  assign drop       = bus.inst_data_ok & (discard_q != '0);
  assign fill       = bus.inst_data_ok & (discard_q == '0);
  assign head_valid = (count_q != '0) & filled_q[head_ptr_q];
  assign pop        = head_valid & bus.id_ready & ~bus.flush;

  assign bus.inst_req  = req;
  assign bus.inst_addr = bus.pc;
  assign bus.pc_en     = accept;
  assign bus.id_valid  = head_valid;
  assign bus.id_pc     = pc_q[head_ptr_q];
  assign bus.id_inst   = inst_q[head_ptr_q];

  always_comb begin
    alloc_ptr_d = alloc_ptr_q + PW'(accept);
    fill_ptr_d  = fill_ptr_q  + PW'(fill);
    head_ptr_d  = head_ptr_q  + PW'(pop);
    count_d     = count_q + CW'(accept) - CW'(pop);
    pend_d      = pend_q  + CW'(accept) - CW'(fill);
    discard_d   = discard_q - CW'(drop);
    if (bus.flush) begin
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      count_d     = '0;
      pend_d      = '0;
      // Every still-outstanding live request becomes a discard, less the one
      // this cycle's response would have filled.
      discard_d   = discard_q - CW'(drop) + pend_q - CW'(fill);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      pend_q      <= '0;
      discard_q   <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      discard_q   <= discard_d;
    end
  end

  // Accept and fill never target the same slot: accept writes a free slot,
  // fill writes an allocated one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else if (bus.flush) begin
      filled_q <= '0;
    end else begin
      if (accept) begin
        pc_q[alloc_ptr_q]     <= bus.pc;
        filled_q[alloc_ptr_q] <= 1'b0;
      end
      if (fill) begin
        inst_q[fill_ptr_q]   <= bus.inst_rdata;
        filled_q[fill_ptr_q] <= 1'b1;
      end
    end
  end

  // A response with nothing outstanding (live or discarded) is a bus error.
  assert property (@(posedge clk) disable iff (!resetn)
    bus.inst_data_ok |-> ((pend_q != '0) || (discard_q != '0)));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_VEC = 32'hbfc00000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.WIDTH(WIDTH)) bus ();
  inst_fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          filled;
  } ent_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } mreq_t;

  ent_t  q[$];       // allocated entries, oldest first
  mreq_t mem_q[$];   // requests the memory still owes a response for
  int    discard;
  int    vecs = 0;
  int    errs = 0;

  bit          s_pc_ce, s_flush, s_addr_ok, s_data_ok, s_id_ready;
  logic [31:0] pc_r, redirect;
  bit          e_accept, e_pop, e_data_ok;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive this cycle's inputs, then compare combinational outputs with the model.
  task automatic apply();
    bit req, valid;
    bus.pc_ce        = s_pc_ce;
    bus.pc           = pc_r;
    bus.flush        = s_flush;
    bus.id_ready     = s_id_ready;
    bus.inst_addr_ok = s_addr_ok && (mem_q.size() < DEPTH);
    e_data_ok        = s_data_ok && (mem_q.size() > 0);
    bus.inst_data_ok = e_data_ok;
    if (e_data_ok) bus.inst_rdata = mem_q[0].data;
    else           bus.inst_rdata = 32'hdeadbeef;
    req      = s_pc_ce && !s_flush && (q.size() < DEPTH);
    valid    = (q.size() > 0) && q[0].filled;
    e_accept = req && bus.inst_addr_ok;
    e_pop    = valid && s_id_ready && !s_flush;
    #1;
    chk("inst_req", bus.inst_req, req);
    chk("inst_addr", bus.inst_addr, pc_r);
    chk("pc_en", bus.pc_en, e_accept);
    chk("id_valid", bus.id_valid, valid);
    if (valid) begin
      chk("id_pc", bus.id_pc, q[0].pc);
      chk("id_inst", bus.id_inst, q[0].inst);
    end
  endtask

  // Advance one clock and update the model with what happened on that edge.
  task automatic clock();
    mreq_t resp;
    int idx;
    @(posedge clk);
    if (resetn) begin
      if (e_data_ok) begin
        resp = mem_q.pop_front();
        if (discard > 0) discard--;
        else begin
          idx = -1;
          foreach (q[i]) if (!q[i].filled && idx < 0) idx = i;
          if (idx >= 0) begin
            q[idx].inst   = resp.data;
            q[idx].filled = 1'b1;
          end
        end
      end
      if (e_accept) mem_q.push_back('{addr: pc_r, data: $urandom});
      if (s_flush) begin
        foreach (q[i]) if (!q[i].filled) discard++;
        q.delete();
        pc_r = redirect;
      end else begin
        if (e_pop) void'(q.pop_front());
        if (e_accept) begin
          q.push_back('{pc: pc_r, inst: '0, filled: 1'b0});
          pc_r = pc_r + 32'd4;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_stim();
    s_pc_ce = 0; s_flush = 0; s_addr_ok = 0; s_data_ok = 0; s_id_ready = 0;
  endtask

  task automatic model_reset();
    q.delete();
    mem_q.delete();
    discard = 0;
    pc_r = RESET_VEC;
    redirect = RESET_VEC;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_stim();
    model_reset();
    apply(); clock();
    apply(); clock();
    resetn = 1'b1;
  endtask

  int n_acc;

  initial begin
    bus.pc_ce = 0; bus.pc = '0; bus.flush = 0; bus.id_ready = 0;
    bus.inst_addr_ok = 0; bus.inst_data_ok = 0; bus.inst_rdata = '0;
    model_reset();
    @(negedge clk);

    // Reset release, then pc_ce one cycle later, then streaming
    do_reset();
    apply();
    chk("rst_inst_req", bus.inst_req, 0);
    chk("rst_id_valid", bus.id_valid, 0);
    chk("rst_id_pc", bus.id_pc, 0);
    chk("rst_id_inst", bus.id_inst, 0);
    clock();
    s_pc_ce = 1; s_addr_ok = 1;
    apply();
    chk("first_req", bus.inst_req, 1);
    chk("first_addr", bus.inst_addr, RESET_VEC);
    clock();
    s_data_ok = 1; s_id_ready = 1;
    for (int i = 0; i < 12; i++) begin
      apply();
      chk("stream_pc_en", bus.pc_en, 1);
      chk("stream_valid", bus.id_valid, (i == 0) ? 0 : 1);
      if (i > 0) chk("stream_id_pc", bus.id_pc, RESET_VEC + 32'(4 * (i - 1)));
      clock();
    end

    // Backpressure: decode stalled, memory fast
    do_reset();
    s_pc_ce = 1; s_addr_ok = 1; s_data_ok = 1; s_id_ready = 0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      apply();
      n_acc += int'(bus.pc_en);
      clock();
    end
    chk("bp_accepts", n_acc, 4);
    apply();
    chk("bp_full_req", bus.inst_req, 0);
    chk("bp_hold_pc", bus.id_pc, RESET_VEC);
    clock();
    s_id_ready = 1;
    apply();
    chk("bp_pop_req", bus.inst_req, 0);
    chk("bp_pop_pc", bus.id_pc, RESET_VEC);
    clock();
    apply();
    chk("bp_resume_req", bus.inst_req, 1);
    chk("bp_next_pc", bus.id_pc, RESET_VEC + 32'd4);
    clock();
    for (int i = 0; i < 6; i++) begin apply(); clock(); end

    // Flush with three requests in flight, then redirect
    do_reset();
    s_pc_ce = 1; s_addr_ok = 1; s_id_ready = 1;
    for (int i = 0; i < 3; i++) begin apply(); clock(); end
    s_flush = 1; redirect = 32'hbfc00380;
    apply();
    chk("fl_req_low", bus.inst_req, 0);
    clock();
    s_flush = 0;
    apply();
    chk("fl_redirect_addr", bus.inst_addr, 32'hbfc00380);
    chk("fl_redirect_acc", bus.pc_en, 1);
    clock();
    s_pc_ce = 0; s_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      apply();
      chk("fl_dropped", bus.id_valid, 0);
      clock();
    end
    s_data_ok = 0;
    apply();
    chk("fl_deliver_valid", bus.id_valid, 1);
    chk("fl_deliver_pc", bus.id_pc, 32'hbfc00380);
    clock();

    // Flush coincident with data_ok and pop
    do_reset();
    s_pc_ce = 1; s_addr_ok = 1;
    for (int i = 0; i < 3; i++) begin apply(); clock(); end
    s_pc_ce = 0; s_data_ok = 1;
    apply(); clock();
    s_flush = 1; s_id_ready = 1; redirect = RESET_VEC + 32'h100;
    apply(); clock();
    s_flush = 0; s_data_ok = 0;
    apply();
    chk("fc_valid", bus.id_valid, 0);
    chk("fc_model_discard", discard, 1);
    chk("fc_discard_cnt", 32'(dut.discard_q), 1);
    clock();
    s_data_ok = 1;
    apply(); clock();
    s_data_ok = 0;
    apply();
    chk("fc_after_drop_valid", bus.id_valid, 0);
    chk("fc_discard_zero", 32'(dut.discard_q), 0);
    clock();

    // Asynchronous reset with the queue partly full
    do_reset();
    s_pc_ce = 1; s_addr_ok = 1;
    for (int i = 0; i < 2; i++) begin apply(); clock(); end
    s_pc_ce = 0; s_data_ok = 1;
    apply(); clock();
    s_data_ok = 0;
    apply();
    chk("ar_pre_valid", bus.id_valid, 1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_valid_drop", bus.id_valid, 0);
    chk("ar_count", 32'(dut.count_q), 0);
    clear_stim();
    model_reset();
    @(negedge clk);
    apply(); clock();
    resetn = 1'b1;
    s_pc_ce = 1; s_addr_ok = 1;
    apply();
    chk("ar_refetch_req", bus.inst_req, 1);
    chk("ar_refetch_addr", bus.inst_addr, RESET_VEC);
    clock();

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      s_pc_ce    = ($urandom % 10) != 0;
      s_flush    = ($urandom % 25) == 0;
      s_addr_ok  = ($urandom % 10) < 7;
      s_data_ok  = ($urandom % 10) < 6;
      s_id_ready = ($urandom % 10) < 7;
      redirect   = $urandom & 32'hfffffffc;
      apply();
      clock();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
